// File: rtl/definitions_pkg.sv
// Shared definitions for the load-immediate expander: RV32I opcodes,
// 12-bit signed immediate range, FSM state and encoder format selector.
package definitions_pkg;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

    // Signed range reachable by a single ADDI from x0
    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EMIT_LUI  = 2'd1,
        EMIT_ADDI = 2'd2
    } li_state_e;

    typedef enum logic {
        IMM_SRC_U = 1'b0,
        IMM_SRC_I = 1'b1
    } imm_src_e;

    // True when the constant sign-fits in a 12-bit immediate
    function automatic logic fits_imm12(input logic [31:0] value);
        return ($signed(value) >= IMM12_MIN) && ($signed(value) <= IMM12_MAX);
    endfunction

    // Upper part for LUI, pre-compensated for ADDI sign-extending the low part
    function automatic logic [19:0] hi20(input logic [31:0] value);
        logic [31:0] sum;
        sum = value + 32'h0000_0800;
        return sum[31:12];
    endfunction

endpackage

// File: rtl/li_expander_encode_imm.sv
// Pure field packer for the two instruction formats used by li_expander:
// U-type (LUI) and I-type (ADDI, funct3 = 000).
module encode_imm
    import definitions_pkg::*;
(
    input  imm_src_e    imm_src,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [19:0] imm,
    output logic [31:0] instr
);

    // Pack fields; I-format uses only the low 12 immediate bits
    always_comb begin
        instr = '0;
        case (imm_src)
            IMM_SRC_U: instr = {imm, rd, OPCODE_LUI};
            IMM_SRC_I: instr = {imm[11:0], rs1, 3'b000, rd, OPCODE_OP_IMM};
            default:   instr = '0;
        endcase
    end

endmodule

// File: rtl/li_expander.sv
// Load-immediate expander: turns (rd, 32-bit constant) into an RV32I
// LUI/ADDI sequence on a valid/ready stream. All outputs are registered.
// Build option: define LI_SHORT_FORM_EN to emit the shortest sequence
// (single ADDI for 12-bit signed constants, lone LUI when the low part is 0).
module li_expander
    import definitions_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [4:0]  req_rd_i,
    input  logic [31:0] req_value_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic        instr_last_o,
    output logic        busy_o
);

`ifdef LI_SHORT_FORM_EN
    localparam bit SHORT_FORM = 1'b1;
`else
    localparam bit SHORT_FORM = 1'b0;
`endif

    li_state_e   state_reg;
    logic [4:0]  rd_reg;
    logic [11:0] lo_reg;
    logic [31:0] instr_reg;
    logic        valid_reg;
    logic        last_reg;
    logic        busy_reg;
    logic        ready_reg;

    logic        accept;
    logic        handshake;
    logic        req_short;
    logic        req_lui_only;

    imm_src_e    enc_src;
    logic [4:0]  enc_rd;
    logic [4:0]  enc_rs1;
    logic [19:0] enc_imm;
    logic [31:0] enc_instr;

    assign accept    = req_valid_i && ready_reg;
    assign handshake = valid_reg && instr_ready_i;

    // Sequence shape is decided once, from the incoming request
    assign req_short    = SHORT_FORM && fits_imm12(req_value_i);
    assign req_lui_only = SHORT_FORM && (req_value_i[11:0] == 12'h000) && !req_short;

    // Choose what the encoder builds: the first instruction of a new request
    // while idle, otherwise the follow-up ADDI rd, rd, lo from stored fields
    always_comb begin
        enc_src = IMM_SRC_I;
        enc_rd  = rd_reg;
        enc_rs1 = rd_reg;
        enc_imm = {8'h00, lo_reg};
        if (state_reg == IDLE) begin
            enc_rd = req_rd_i;
            if (req_short) begin
                enc_src = IMM_SRC_I;
                enc_rs1 = 5'd0;
                enc_imm = {8'h00, req_value_i[11:0]};
            end else begin
                enc_src = IMM_SRC_U;
                enc_rs1 = 5'd0;
                enc_imm = hi20(req_value_i);
            end
        end
    end

    encode_imm u_encode_imm (
        .imm_src (enc_src),
        .rd      (enc_rd),
        .rs1     (enc_rs1),
        .imm     (enc_imm),
        .instr   (enc_instr)
    );

    // Sequencer FSM with registered outputs; reset drops any pending sequence
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            rd_reg    <= '0;
            lo_reg    <= '0;
            instr_reg <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        rd_reg    <= req_rd_i;
                        lo_reg    <= req_value_i[11:0];
                        instr_reg <= enc_instr;
                        valid_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                        ready_reg <= 1'b0;
                        if (req_short) begin
                            state_reg <= EMIT_ADDI;
                            last_reg  <= 1'b1;
                        end else begin
                            state_reg <= EMIT_LUI;
                            last_reg  <= req_lui_only;
                        end
                    end
                end
                EMIT_LUI: begin
                    if (handshake) begin
                        if (last_reg) begin
                            state_reg <= IDLE;
                            instr_reg <= '0;
                            valid_reg <= 1'b0;
                            last_reg  <= 1'b0;
                            busy_reg  <= 1'b0;
                            ready_reg <= 1'b1;
                        end else begin
                            state_reg <= EMIT_ADDI;
                            instr_reg <= enc_instr;
                            last_reg  <= 1'b1;
                        end
                    end
                end
                EMIT_ADDI: begin
                    if (handshake) begin
                        state_reg <= IDLE;
                        instr_reg <= '0;
                        valid_reg <= 1'b0;
                        last_reg  <= 1'b0;
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    instr_reg <= '0;
                    valid_reg <= 1'b0;
                    last_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o   = ready_reg;
    assign instr_valid_o = valid_reg;
    assign instr_o       = instr_reg;
    assign instr_last_o  = last_reg;
    assign busy_o        = busy_reg;

endmodule

// File: tb/tb_li_expander.sv
// Self-checking bench for li_expander: directed cases, a stall case,
// a mid-sequence reset and randomized constants against an arithmetic model.
module tb_li_expander;

`ifdef LI_SHORT_FORM_EN
    localparam bit MODEL_SHORT = 1'b1;
`else
    localparam bit MODEL_SHORT = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [4:0]  req_rd_i;
    logic [31:0] req_value_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic        instr_last_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    li_expander dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_rd_i      (req_rd_i),
        .req_value_i   (req_value_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_last_o  (instr_last_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: arithmetic split and field placement by multiplication/shifts
    function automatic logic [31:0] mk_lui(input int unsigned rd, input int unsigned hi);
        return (hi * 4096) + (rd * 128) + 32'h37;
    endfunction

    function automatic logic [31:0] mk_addi(input int unsigned rd, input int unsigned rs1,
                                            input int unsigned lo);
        return (lo * 32'h0010_0000) + (rs1 * 32768) + (rd * 128) + 32'h13;
    endfunction

    task automatic build_expected(input int unsigned rd, input logic [31:0] v);
        int signed   sv;
        int unsigned lo;
        int unsigned hi;
        sv = int'(v);
        lo = v % 4096;
        hi = (v + 32'd2048) / 4096;
        exp_q.delete();
        if (MODEL_SHORT && sv >= -2048 && sv <= 2047) begin
            exp_q.push_back(mk_addi(rd, 0, lo));
        end else if (MODEL_SHORT && lo == 0) begin
            exp_q.push_back(mk_lui(rd, hi));
        end else begin
            exp_q.push_back(mk_lui(rd, hi));
            exp_q.push_back(mk_addi(rd, rd, lo));
        end
    endtask

    // One full request: accept, then drain the sequence with optional stalls
    task automatic do_seq(input logic [4:0] rd, input logic [31:0] v,
                          input int forced_stall, input int stall_pct);
        int   stalls;
        bit   done;
        logic [31:0] held;
        build_expected(rd, v);
        check("idle_req_ready", {31'b0, req_ready_o}, 32'd1);
        check("idle_busy", {31'b0, busy_o}, 32'd0);
        check("idle_valid", {31'b0, instr_valid_o}, 32'd0);
        req_valid_i   = 1'b1;
        req_rd_i      = rd;
        req_value_i   = v;
        instr_ready_i = 1'b0;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        req_rd_i    = 5'($urandom);
        req_value_i = $urandom;
        for (int i = 0; i < exp_q.size(); i++) begin
            stalls = 0;
            done   = 1'b0;
            held   = instr_o;
            while (!done) begin
                check("valid", {31'b0, instr_valid_o}, 32'd1);
                check("busy", {31'b0, busy_o}, 32'd1);
                check("req_ready_low", {31'b0, req_ready_o}, 32'd0);
                check("instr", instr_o, exp_q[i]);
                check("stable", instr_o, held);
                check("last", {31'b0, instr_last_o}, (i == exp_q.size() - 1) ? 32'd1 : 32'd0);
                if ((i == 0 && stalls < forced_stall) ||
                    (stalls < 8 && $urandom_range(0, 99) < stall_pct)) begin
                    instr_ready_i = 1'b0;
                    stalls++;
                end else begin
                    instr_ready_i = 1'b1;
                    done = 1'b1;
                end
                @(negedge clk_i);
            end
        end
        instr_ready_i = 1'b0;
        check("done_valid", {31'b0, instr_valid_o}, 32'd0);
        check("done_busy", {31'b0, busy_o}, 32'd0);
        $display("seq rd=%0d value=%h instrs=%0d", rd, v, exp_q.size());
    endtask

    logic [31:0] rv;
    logic [4:0]  rr;

    initial begin
        rst_i         = 1'b1;
        req_valid_i   = 1'b0;
        req_rd_i      = '0;
        req_value_i   = '0;
        instr_ready_i = 1'b0;
        #3;
        check("rst_valid", {31'b0, instr_valid_o}, 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_last", {31'b0, instr_last_o}, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_req_ready", {31'b0, req_ready_o}, 32'd1);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Directed cases
        do_seq(5'd5, 32'h1234_5678, 0, 0);
        @(negedge clk_i);
        do_seq(5'd1, 32'h0000_0FFF, 0, 0);
        @(negedge clk_i);
        do_seq(5'd10, 32'hFFFF_F800, 0, 0);
        @(negedge clk_i);
        do_seq(5'd2, 32'hABCD_E000, 0, 0);
        @(negedge clk_i);
        do_seq(5'd0, 32'h0000_07FF, 0, 0);
        @(negedge clk_i);
        do_seq(5'd31, 32'h8000_0000, 0, 0);
        @(negedge clk_i);
        // Output held for three cycles while the consumer stalls
        do_seq(5'd5, 32'h1234_5678, 3, 0);
        @(negedge clk_i);

        // Reset in the middle of a LUI/ADDI sequence
        req_valid_i = 1'b1;
        req_rd_i    = 5'd7;
        req_value_i = 32'h1234_5678;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check("pre_rst_instr", instr_o, mk_lui(7, 32'h12345));
        rst_i = 1'b1;
        #1;
        check("mid_rst_valid", {31'b0, instr_valid_o}, 32'd0);
        check("mid_rst_busy", {31'b0, busy_o}, 32'd0);
        check("mid_rst_req_ready", {31'b0, req_ready_o}, 32'd1);
        check("mid_rst_instr", instr_o, 32'd0);
        @(negedge clk_i);
        rst_i         = 1'b0;
        instr_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            check("post_rst_no_instr", {31'b0, instr_valid_o}, 32'd0);
            check("post_rst_idle", {31'b0, busy_o}, 32'd0);
        end
        instr_ready_i = 1'b0;
        $display("reset mid-sequence rd=7 value=12345678");

        // Randomized constants across the interesting value classes
        for (int n = 0; n < 60; n++) begin
            rr = 5'($urandom);
            case ($urandom_range(0, 3))
                0: rv = $urandom;
                1: rv = 32'($urandom_range(0, 4095)) - 32'd2048;
                2: rv = $urandom & 32'hFFFF_F000;
                default: rv = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(32'h7FE, 32'h801));
            endcase
            do_seq(rr, rv, 0, 30);
            @(negedge clk_i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/li_expander.md
LI_EXPANDER -- requirements
Module: li_expander

Interface
REQ-001 The module SHALL declare these ports, clock and reset first:
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  load-immediate request valid
- req_ready_o  out  1  request accepted when high with req_valid_i
- req_rd_i  in  5  destination register index
- req_value_i  in  32  constant to materialise (word_32ut)
- instr_valid_o  out  1  encoded instruction valid
- instr_ready_i  in  1  downstream accepts instr_o
- instr_o  out  32  encoded RV32I instruction (word_32ut)
- instr_last_o  out  1  instr_o is final instruction of sequence
- busy_o  out  1  sequence in progress

Function
REQ-002 Accept SHALL occur when req_valid_i and req_ready_o are both high at a rising edge; rd and value SHALL be registered on accept.
REQ-003 req_ready_o SHALL be high only in IDLE, giving one idle cycle between sequences.
REQ-004 Split rule: lo = value[11:0]; hi = (value + 32'h800)[31:12], with the addition mod 2^32, so sign-extended lo plus hi<<12 equals value.
REQ-005 LUI encoding SHALL be {hi, rd, 7'b0110111}; ADDI encoding SHALL be {lo, rs1, 3'b000, rd, 7'b0010011}.
REQ-006 FSM states SHALL be IDLE, EMIT_LUI and EMIT_ADDI.
- IDLE: accept -> EMIT_LUI, or -> EMIT_ADDI for the short form.
- EMIT_LUI: output handshake -> EMIT_ADDI, or -> IDLE if LUI-only.
- EMIT_ADDI: output handshake -> IDLE.
REQ-007 instr_valid_o SHALL rise in the cycle after accept (latency 1) and stay high in every EMIT state.
REQ-008 While instr_valid_o is high and instr_ready_i is low, instr_o and instr_last_o SHALL remain stable.
REQ-009 instr_last_o SHALL be high exactly on the final instruction of a sequence.
REQ-010 busy_o SHALL be high in any state other than IDLE.
REQ-011 rd = 0 SHALL be encoded normally, with no special case.
REQ-012 Outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-013 rst_i high SHALL immediately force IDLE, instr_valid_o=0, instr_o=0, instr_last_o=0, busy_o=0 and req_ready_o=1.
REQ-014 A reset mid-sequence SHALL discard the pending sequence; no further instruction of it SHALL be emitted.

Configuration
REQ-015 Macro LI_SHORT_FORM_EN SHALL select short forms, as follows.
- Defined, value in [-2048, 2047]: emit a single ADDI rd, x0, lo.
- Defined, otherwise if lo == 0: emit LUI only.
- Defined, all other values: LUI then ADDI.
- Not defined: always LUI then ADDI (rs1 = rd).

Structure
REQ-016 definitions_pkg SHALL hold OPCODE_LUI, OPCODE_OP_IMM, the 12-bit range constants and the li_state_e enum.
REQ-017 The combinational field-packing logic SHALL be a sub-module encode_imm: imm_src_e, rd, rs1 and immediate in; instruction out (U and I formats).

Verification
REQ-018 A bench SHALL cover the following directed scenarios.
- 0x12345678, rd=5, ready high -> 0x123452B7 (last=0), then 0x67828293 (last=1).
- Carry case: 0x00000FFF, rd=1 -> 0x000010B7, then 0xFFF08093.
- 0xFFFFF800, rd=10: with macro -> single 0x80000513 (last=1); without -> 0x00000537, then 0x80050513.
- 0xABCDE000, rd=2 with macro -> single 0xABCDE137 (last=1).
- Hold instr_ready_i low 3 cycles during EMIT_LUI -> instr_o stable, req_ready_o low, no state advance.
- Assert rst_i in EMIT_LUI -> next cycle instr_valid_o=0, busy_o=0, req_ready_o=1, and no ADDI ever appears.
